regfile: RTL and testbench
==========================

REGFILE -- requirements
Module: regfile

Interface
REQ-001 Parameter DATA_W, default 32, register and data width in bits.
REQ-002 Parameter ADDR_W, default 5, address width; register count is 2**ADDR_W (32).
REQ-003 clk  input  1  single clock; all register writes occur on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Regwrite_i  input  1  write enable; high selects a write of wd_i to wa_i at the next rising clk.
REQ-006 wa_i  input  ADDR_W  write address.
REQ-007 wd_i  input  DATA_W  write data.
REQ-008 ra0_i  input  ADDR_W  read address, port 0.
REQ-009 ra1_i  input  ADDR_W  read address, port 1.
REQ-010 rd0_o  output  DATA_W  read data, port 0.
REQ-011 rd1_o  output  DATA_W  read data, port 1.

Function
REQ-012 Storage SHALL be 2**ADDR_W registers of DATA_W bits each.
REQ-013 On a rising clk with rst_n high and Regwrite_i high, register[wa_i] SHALL load wd_i; the write SHALL be skipped when wa_i is 0.
REQ-014 With Regwrite_i low, no register SHALL change.
REQ-015 Register 0 SHALL read as 0 at all times, on both ports.
REQ-016 Reads SHALL be combinational, zero latency: rd0_o = register[ra0_i] and rd1_o = register[ra1_i].
REQ-017 Write-first bypass: when rst_n is high, Regwrite_i is high and wa_i equals a nonzero read address, that port SHALL output wd_i combinationally, before the clock edge.
REQ-018 The bypassed value and the stored value after the edge SHALL be identical, so a read is stable across the write edge.
REQ-019 Both ports SHALL operate independently; equal ra0_i and ra1_i SHALL return identical data.
REQ-020 A read port whose address differs from wa_i SHALL be unaffected by any write in that cycle.
REQ-021 Address arithmetic SHALL be modulo 2**ADDR_W; every address value is legal and there is no out-of-range case.
REQ-022 Writes SHALL be full-width; there are no byte enables.

Reset
REQ-023 rst_n low SHALL clear all registers to 0 immediately, without waiting for clk.
REQ-024 While rst_n is low, writes SHALL be ignored, bypass SHALL be disabled, and rd0_o and rd1_o SHALL be 0.
REQ-025 On rst_n rising, reads SHALL return 0 until written; the first write SHALL take effect on the first rising clk with rst_n high.
REQ-026 Reset asserted mid-write SHALL win: the targeted register SHALL be 0 after reset.

Structure
REQ-027 A shared package SHALL hold the constants DATA_W=32, ADDR_W=5 and NUM_REGS=32, plus the address and data typedefs.
REQ-028 One sub-module, rf_read_port, SHALL contain the read mux, the zero-register rule and the bypass compare; regfile SHALL instantiate it twice.
REQ-029 Register storage and write logic SHALL reside in regfile.

Verification
REQ-030 Pulse rst_n low for 1 ns after prior writes -> every address reads 0 on both ports.
REQ-031 Write 0xDEADBEEF to address 3, then the next cycle set ra0_i=3, ra1_i=3 with Regwrite_i low -> rd0_o = rd1_o = 0xDEADBEEF.
REQ-032 Write 0x12345678 to address 0, read address 0 -> 0x00000000 on both ports.
REQ-033 Regwrite_i=1, wa_i=7, wd_i=0xA5A5A5A5, ra0_i=7, ra1_i=8 in the same cycle -> rd0_o = 0xA5A5A5A5 before and after the edge, and rd1_o keeps the old value of register 8.
REQ-034 Write 0x1 to address 31, then Regwrite_i=0 with wa_i=31 and wd_i=0xFFFFFFFF -> register 31 still reads 0x00000001.
REQ-035 Write i*0x01010101 to every address i (1..31), then read all address pairs (i, 31-i) -> values match on both ports, and address 0 reads 0.

Source files
------------

// File: rtl/regfile_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// regfile_pkg : shared constants and types for the register file
// Rev 1.0
// ----------------------------------------------------------------------------
package regfile_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

endpackage
`default_nettype wire

// File: rtl/rf_read_port.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rf_read_port : one combinational read port with zero-register and bypass
// Rev 1.0
// ----------------------------------------------------------------------------
module rf_read_port #(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic [DATA_W-1:0] regs [2**ADDR_W],
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] ra,
  output logic [DATA_W-1:0] rd
);
  import regfile_pkg::*;

  // wr_en arrives already gated by reset, so the bypass is off during reset
  always_comb begin
    rd = '0;
    if (ra != '0) begin
      if (wr_en && (wa == ra)) begin
        rd = wd;
      end else begin
        rd = regs[ra];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/regfile.sv
`default_nettype none
// ----------------------------------------------------------------------------
// regfile : 2**ADDR_W x DATA_W register file, one write port, two read ports
// Rev 1.0
// ----------------------------------------------------------------------------
module regfile #(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Regwrite_i,
  input  logic [ADDR_W-1:0] wa_i,
  input  logic [DATA_W-1:0] wd_i,
  input  logic [ADDR_W-1:0] ra0_i,
  input  logic [ADDR_W-1:0] ra1_i,
  output logic [DATA_W-1:0] rd0_o,
  output logic [DATA_W-1:0] rd1_o
);
  import regfile_pkg::*;

  localparam int N_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [N_REGS];
  logic              bypass_en;

  assign bypass_en = Regwrite_i & rst_n;

  // Register 0 is never written and stays at its reset value of zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (Regwrite_i && (wa_i != '0)) begin
      regs[wa_i] <= wd_i;
    end
  end

  rf_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rd0 (
    .regs  (regs),
    .wr_en (bypass_en),
    .wa    (wa_i),
    .wd    (wd_i),
    .ra    (ra0_i),
    .rd    (rd0_o)
  );

  rf_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rd1 (
    .regs  (regs),
    .wr_en (bypass_en),
    .wa    (wa_i),
    .wd    (wd_i),
    .ra    (ra1_i),
    .rd    (rd1_o)
  );

endmodule
`default_nettype wire

// File: tb/tb_regfile.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_regfile : directed and randomized self-checking bench for regfile
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_regfile;
  import regfile_pkg::*;

  logic  clk = 1'b0;
  logic  rst_n;
  logic  Regwrite_i;
  addr_t wa_i, ra0_i, ra1_i;
  data_t wd_i;
  data_t rd0_o, rd1_o;

  int    n_checks = 0;
  int    n_errors = 0;
  data_t model [NUM_REGS];

  always #5 clk = ~clk;

  regfile dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Regwrite_i (Regwrite_i),
    .wa_i       (wa_i),
    .wd_i       (wd_i),
    .ra0_i      (ra0_i),
    .ra1_i      (ra1_i),
    .rd0_o      (rd0_o),
    .rd1_o      (rd1_o)
  );

  task automatic check(input string tag, input data_t got, input data_t exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference read: zero register, then write-first forwarding, then storage
  function automatic data_t ref_read(input addr_t ra);
    if (ra == 0) return '0;
    if (rst_n !== 1'b1) return '0;
    if (Regwrite_i && wa_i == ra) return wd_i;
    return model[ra];
  endfunction

  task automatic model_clear();
    foreach (model[i]) model[i] = '0;
  endtask

  task automatic model_clock();
    if (rst_n && Regwrite_i && wa_i != 0) model[wa_i] = wd_i;
  endtask

  task automatic check_ports(input string tag);
    check({tag, "_rd0"}, rd0_o, ref_read(ra0_i));
    check({tag, "_rd1"}, rd1_o, ref_read(ra1_i));
  endtask

  task automatic wr(input addr_t a, input data_t d);
    @(negedge clk);
    Regwrite_i = 1'b1; wa_i = a; wd_i = d;
    @(posedge clk);
    model_clock();
    #1;
    Regwrite_i = 1'b0;
  endtask

  task automatic sweep_all(input string tag);
    for (int i = 0; i < NUM_REGS; i++) begin
      ra0_i = addr_t'(i); ra1_i = addr_t'(NUM_REGS - 1 - i);
      #1;
      check_ports(tag);
    end
  endtask

  initial begin
    rst_n = 1'b0; Regwrite_i = 1'b0; wa_i = '0; wd_i = '0;
    ra0_i = '0; ra1_i = '0;
    model_clear();
    #1;
    check("reset_rd0", rd0_o, '0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Write then read back on both ports
    wr(5'd3, 32'hDEADBEEF);
    @(negedge clk);
    ra0_i = 5'd3; ra1_i = 5'd3; #1;
    check("wr3_rd0", rd0_o, 32'hDEADBEEF);
    check("wr3_rd1", rd1_o, 32'hDEADBEEF);

    // Address 0 ignores writes
    wr(5'd0, 32'h12345678);
    ra0_i = 5'd0; ra1_i = 5'd0; #1;
    check("zero_rd0", rd0_o, 32'h0);
    check("zero_rd1", rd1_o, 32'h0);

    // Bypass on port 0, port 1 undisturbed, stable across edge
    wr(5'd8, 32'h0BADF00D);
    @(negedge clk);
    Regwrite_i = 1'b1; wa_i = 5'd7; wd_i = 32'hA5A5A5A5;
    ra0_i = 5'd7; ra1_i = 5'd8; #1;
    check("byp_pre_rd0", rd0_o, 32'hA5A5A5A5);
    check("byp_pre_rd1", rd1_o, 32'h0BADF00D);
    @(posedge clk); model_clock(); #1;
    check("byp_post_rd0", rd0_o, 32'hA5A5A5A5);
    check("byp_post_rd1", rd1_o, 32'h0BADF00D);
    Regwrite_i = 1'b0;

    // Disabled write leaves register 31 alone
    wr(5'd31, 32'h1);
    @(negedge clk);
    Regwrite_i = 1'b0; wa_i = 5'd31; wd_i = 32'hFFFFFFFF; ra0_i = 5'd31;
    @(posedge clk); #1;
    check("nowr_rd0", rd0_o, 32'h00000001);

    // Fill every register and read mirrored pairs
    for (int i = 1; i < NUM_REGS; i++) wr(addr_t'(i), data_t'(i) * 32'h01010101);
    @(negedge clk);
    sweep_all("fill");
    ra0_i = 5'd0; ra1_i = 5'd31; #1;
    check("fill_a0", rd0_o, 32'h0);
    check("fill_a31", rd1_o, 32'h1F1F1F1F);

    // 1 ns reset pulse between edges clears everything
    @(negedge clk);
    rst_n = 1'b0; #1;
    model_clear();
    check("rst_pulse_rd1", rd1_o, 32'h0);
    rst_n = 1'b1;
    sweep_all("rst_pulse");

    // Reset asserted during a pending write wins; bypass disabled meanwhile
    wr(5'd5, 32'hCAFEF00D);
    @(negedge clk);
    Regwrite_i = 1'b1; wa_i = 5'd5; wd_i = 32'h55AA55AA;
    ra0_i = 5'd5; ra1_i = 5'd5;
    #2 rst_n = 1'b0; #1;
    model_clear();
    check("rst_byp_rd0", rd0_o, 32'h0);
    check("rst_byp_rd1", rd1_o, 32'h0);
    @(posedge clk); #1;
    check("rst_hold_rd0", rd0_o, 32'h0);
    Regwrite_i = 1'b0;
    @(negedge clk); rst_n = 1'b1; #1;
    check("rst_win_rd0", rd0_o, 32'h0);

    // First write after reset release lands on the first edge
    wr(5'd9, 32'h13579BDF);
    ra0_i = 5'd9; #1;
    check("post_rst_wr", rd0_o, 32'h13579BDF);

    // Randomized traffic with forwarding checks before and after each edge
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      Regwrite_i = 1'($urandom_range(0, 1));
      wa_i  = addr_t'($urandom_range(0, NUM_REGS - 1));
      wd_i  = data_t'($urandom);
      ra0_i = ($urandom_range(0, 3) == 0) ? wa_i : addr_t'($urandom_range(0, NUM_REGS - 1));
      ra1_i = ($urandom_range(0, 3) == 0) ? wa_i : addr_t'($urandom_range(0, NUM_REGS - 1));
      if ($urandom_range(0, 7) == 0) ra1_i = ra0_i;
      #1;
      check_ports("rnd_pre");
      if (ra0_i == ra1_i) check("rnd_same", rd0_o, rd1_o);
      @(posedge clk);
      model_clock();
      #1;
      check_ports("rnd_post");
    end

    @(negedge clk);
    Regwrite_i = 1'b0;
    sweep_all("final");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
